// File: rtl/uart_controller_v2.sv
// uart_controller_v2: register-mapped UART with FIFOs, programmable divisor, parity, sticky errors, irq and loopback
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [7:0]   din,
  output logic [7:0]   dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
  always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

module uart_controller_v2 #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE = 19200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [15:0] data,
  output logic [15:0] data_out,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DEFAULT_DIVISOR = 16'(CLOCK_FREQUENCY / BAUD_RATE - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_e;
  logic [5:0] ctrl_q;
  logic [15:0] div_q, data_out_q, status, rd_mux;
  logic [3:0] flags_q, flags_d, w1c;
  logic irq_q, irq_d, tx_idle, txovf_set, ovr_set, ferr_set, perr_set;
  logic [7:0] tx_head, rx_head;
  logic [AW:0] tx_count, rx_count;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
  state_e tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half_m1;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d;
  logic tx_done, tx_line, rx_src, rx_s1_q, rx_s2_q, rx_s3_q, smp;
  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_txf (.clk(clk), .rst(rst), .push(wr_en && addr == 2'd0), .pop(tx_pop),
    .din(data[7:0]), .dout(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty));
  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rxf (.clk(clk), .rst(rst), .push(rx_push), .pop(rd_en && addr == 2'd0),
    .din(rx_sh_q), .dout(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty));
  assign tx_idle = tx_empty && tx_st_q == S_IDLE;
  assign status = {8'(rx_count), 1'b0, flags_q, !rx_empty, tx_idle, !tx_full};
  assign rd_mux = addr == 2'd0 ? (rx_empty ? 16'h0 : {8'h0, rx_head}) :
                  addr == 2'd1 ? status : addr == 2'd2 ? {10'h0, ctrl_q} : div_q;
  assign w1c = (wr_en && addr == 2'd1) ? data[6:3] : 4'h0;
  assign txovf_set = wr_en && addr == 2'd0 && tx_full;
  assign flags_d = (flags_q & ~w1c) | {txovf_set, perr_set, ferr_set, ovr_set};
  assign irq_d = (ctrl_q[2] && !rx_empty) || (ctrl_q[3] && tx_idle) || (ctrl_q[4] && |flags_q);
  assign data_out = data_out_q;
  assign irq = irq_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ctrl_q <= '0;
      div_q <= DEFAULT_DIVISOR;
      data_out_q <= '0;
      flags_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && addr == 2'd2) ctrl_q <= data[5:0];
      if (wr_en && addr == 2'd3) div_q <= data < 16'd3 ? 16'd3 : data;
      if (rd_en) data_out_q <= rd_mux;
      flags_q <= flags_d;
      irq_q <= irq_d;
    end
  assign tx_done = tx_cnt_q == tx_div_q;
  assign tx_line = tx_st_q == S_START ? 1'b0 : tx_st_q == S_DATA ? tx_sh_q[0] : tx_st_q == S_PAR ? tx_par_q : 1'b1;
  assign tx = ctrl_q[5] | tx_line;
  always_comb begin
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q + 16'd1;
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_pen_d = tx_pen_q;
    tx_pop = 1'b0;
    case (tx_st_q)
      S_IDLE: tx_cnt_d = '0;
      S_START: if (tx_done) begin tx_st_d = S_DATA; tx_cnt_d = '0; tx_bit_d = '0; end
      S_DATA: if (tx_done) begin
        tx_cnt_d = '0;
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_st_d = tx_pen_q ? S_PAR : S_STOP;
      end
      S_PAR: if (tx_done) begin tx_st_d = S_STOP; tx_cnt_d = '0; end
      S_STOP: if (tx_done) begin tx_st_d = S_IDLE; tx_cnt_d = '0; end
      default: tx_st_d = S_IDLE;
    endcase
    // the next frame starts straight out of the stop bit, so back-to-back frames have no idle gap
    if ((tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_done)) && !tx_empty) begin
      tx_pop = 1'b1;
      tx_st_d = S_START;
      tx_cnt_d = '0;
      tx_div_d = div_q;
      tx_sh_d = tx_head;
      tx_pen_d = ctrl_q[0];
      tx_par_d = ^tx_head ^ ctrl_q[1];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st_q <= S_IDLE;
      tx_cnt_q <= '0;
      tx_div_q <= DEFAULT_DIVISOR;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_par_q <= 1'b0;
      tx_pen_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_div_q <= tx_div_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_par_q <= tx_par_d;
      tx_pen_q <= tx_pen_d;
    end
  assign rx_src = ctrl_q[5] ? tx_line : rx;
  assign rx_half_m1 = 16'(({1'b0, rx_div_q} + 17'd1) >> 1) - 16'd1;
  assign smp = rx_cnt_q == (rx_st_q == S_START ? rx_half_m1 : rx_div_q);
  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_div_d = rx_div_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_pen_d = rx_pen_q;
    rx_podd_d = rx_podd_q;
    rx_push = 1'b0;
    ovr_set = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) begin
          rx_st_d = S_START;
          rx_div_d = div_q;
          rx_pen_d = ctrl_q[0];
          rx_podd_d = ctrl_q[1];
        end
      end
      S_START: if (smp) begin rx_cnt_d = '0; rx_bit_d = '0; rx_st_d = rx_s2_q ? S_IDLE : S_DATA; end
      S_DATA: if (smp) begin
        rx_cnt_d = '0;
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = rx_pen_q ? S_PAR : S_STOP;
      end
      S_PAR: if (smp) begin
        rx_cnt_d = '0;
        perr_set = rx_s2_q != (^rx_sh_q ^ rx_podd_q);
        rx_st_d = S_STOP;
      end
      S_STOP: if (smp) begin
        rx_cnt_d = '0;
        rx_push = rx_s2_q;
        ovr_set = rx_s2_q && rx_full;
        ferr_set = !rx_s2_q;
        rx_st_d = rx_s2_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin rx_cnt_d = '0; if (rx_s2_q) rx_st_d = S_IDLE; end
      default: rx_st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
      rx_st_q <= S_IDLE;
      rx_cnt_q <= '0;
      rx_div_q <= DEFAULT_DIVISOR;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_pen_q <= 1'b0;
      rx_podd_q <= 1'b0;
    end else begin
      {rx_s1_q, rx_s2_q, rx_s3_q} <= {rx_src, rx_s1_q, rx_s2_q};
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_pen_q <= rx_pen_d;
      rx_podd_q <= rx_podd_d;
    end
endmodule

// File: tb/tb_uart_controller_v2.sv
// tb_uart_controller_v2: randomized register/serial checks against a frame-level UART model
module tb_uart_controller_v2;
  localparam int DEPTH = 4;
  localparam int DEF_DIV = 50_000_000 / 19200 - 1;
  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0, rx = 1;
  logic [1:0] addr = 0;
  logic [15:0] data = 0, data_out, st, d;
  logic tx, irq;
  int n_chk = 0, n_fail = 0;
  logic [7:0] rxq[$];
  logic m_ovr = 0, m_ferr = 0, m_perr = 0;
  uart_controller_v2 #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .data(data), .data_out(data_out), .rx(rx), .tx(tx), .irq(irq));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] v);
    addr = a; data = v; wr_en = 1; tick(); wr_en = 0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    addr = a; rd_en = 1; tick(); rd_en = 0; v = data_out;
  endtask
  function automatic logic [15:0] exp_status();
    return {8'(rxq.size()), 1'b0, 1'b0, m_perr, m_ferr, m_ovr, rxq.size() != 0, 1'b1, 1'b1};
  endfunction
  task automatic model_push(input logic [7:0] b);
    if (rxq.size() < DEPTH) rxq.push_back(b); else m_ovr = 1;
  endtask
  task automatic clear_flags();
    wr(1, 16'h0078); m_ovr = 0; m_ferr = 0; m_perr = 0;
  endtask
  task automatic drive_frame(input logic [7:0] b, input int p, input logic pen, podd, badpar, stopv);
    rx = 0; repeat (p) tick();
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (p) tick(); end
    if (pen) begin rx = (^b) ^ podd ^ badpar; repeat (p) tick(); end
    rx = stopv; repeat (p) tick(); rx = 1;
  endtask
  task automatic tx_frame_check(input logic [7:0] b, input int div, input logic pen, podd);
    int p, l, h;
    logic bits[11];
    logic [15:0] s;
    p = div + 1; l = pen ? 11 : 10; h = p / 2;
    bits[0] = 0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9] = pen ? (^b) ^ podd : 1'b1;
    bits[10] = 1;
    wr(3, 16'(div)); wr(2, {14'h0, podd, pen});
    wr(0, {8'h0, b});
    check("tx_pre_start", tx, 1);
    tick();
    check("tx_start_edge", tx, 0);
    repeat (h) tick();
    for (int k = 0; k < l; k++) begin
      check($sformatf("tx_bit%0d", k), tx, bits[k]);
      if (k < l - 1) repeat (p) tick();
    end
    repeat (p - 1 - h) tick();
    rd(1, s); check("tx_busy_last", s[1], 0);
    rd(1, s); check("tx_idle_after", s[1], 1);
  endtask
  initial begin
    logic [7:0] b;
    logic pen, podd, bad, got, pirq;
    int div, p;
    logic [7:0] bytes[5];
    repeat (3) tick();
    check("rst_tx", tx, 1); check("rst_irq", irq, 0);
    rst = 0; tick();
    rd(0, d); check("rst_data", d, 16'h0000);
    rd(1, d); check("rst_status", d, 16'h0003);
    rd(2, d); check("rst_ctrl", d, 16'h0000);
    rd(3, d); check("rst_div", d, 16'(DEF_DIV));
    wr(3, 16'd1); rd(3, d); check("div_clamp1", d, 16'd3);
    wr(3, 16'd4); rd(3, d); check("div_4", d, 16'd4);
    wr(2, 16'hFFFF); rd(2, d); check("ctrl_mask", d, 16'h003F);
    wr(2, 16'h0000);
    tx_frame_check(8'hA5, 9, 0, 0);
    for (int i = 0; i < 3; i++)
      tx_frame_check(8'($urandom), $urandom_range(3, 12), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) begin
      div = $urandom_range(3, 12); p = div + 1; pen = 1'($urandom); podd = 1'($urandom); b = 8'($urandom);
      if (i == 0) begin div = 9; p = 10; pen = 1; podd = 0; b = 8'h3C; end
      wr(3, 16'(div)); wr(2, {10'h0, 1'b1, 3'b0, podd, pen});
      wr(0, {8'h0, b});
      repeat (2 * p) tick();
      check("lb_tx_pin_high", tx, 1);
      repeat ((10 + pen) * p + 12) tick();
      model_push(b);
      rd(1, d); check("lb_status", d, exp_status());
      rd(0, d); check("lb_data", d, {8'h0, rxq.pop_front()});
    end
    wr(3, 16'd9); wr(2, 16'h0020);
    for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin wr(0, {8'h0, bytes[i]}); model_push(bytes[i]); end
    repeat (530) tick();
    rd(1, d); check("ovr_status", d, exp_status());
    wr(1, 16'h0008); m_ovr = 0;
    rd(1, d); check("ovr_w1c", d, exp_status());
    for (int i = 0; i < 4; i++) begin rd(0, d); check("ovr_drain", d, {8'h0, rxq.pop_front()}); end
    rd(0, d); check("empty_read", d, 16'h0000);
    wr(2, 16'h0000);
    drive_frame(8'($urandom), 10, 0, 0, 0, 0); m_ferr = 1;
    repeat (30) tick();
    rd(1, d); check("frame_err", d, exp_status());
    clear_flags();
    rx = 0; repeat (3) tick(); rx = 1; repeat (40) tick();
    rd(1, d); check("glitch", d, exp_status());
    for (int i = 0; i < 6; i++) begin
      div = $urandom_range(3, 15); p = div + 1; pen = 1'($urandom); podd = 1'($urandom);
      bad = pen && ($urandom_range(0, 2) == 0); b = 8'($urandom);
      wr(3, 16'(div)); wr(2, {14'h0, podd, pen});
      drive_frame(b, p, pen, podd, bad, 1);
      model_push(b); if (bad) m_perr = 1;
      repeat (3 * p) tick();
      rd(1, d); check("rx_status", d, exp_status());
      rd(0, d); check("rx_data", d, {8'h0, rxq.pop_front()});
    end
    clear_flags();
    wr(3, 16'd9); wr(2, 16'h0004);
    check("irq_idle", irq, 0);
    b = 8'($urandom);
    got = 0; pirq = 1;
    fork
      drive_frame(b, 10, 0, 0, 0, 1);
      begin
        for (int i = 0; i < 300 && !got; i++) begin pirq = irq; rd(1, st); got = st[2]; end
        check("irq_push_seen", got, 1);
        check("irq_before_push", pirq, 0);
        check("irq_rise", irq, 1);
      end
    join
    model_push(b);
    rd(0, d); check("irq_data", d, {8'h0, rxq.pop_front()});
    check("irq_hold", irq, 1);
    tick();
    check("irq_fall", irq, 0);
    drive_frame(8'($urandom), 10, 0, 0, 0, 1);
    repeat (30) tick();
    check("irq_again", irq, 1);
    wr(0, 16'h0000);
    repeat (30) tick();
    check("tx_mid_frame", tx, 0);
    #2 rst = 1;
    #1;
    check("rst_async_tx", tx, 1);
    check("rst_async_irq", irq, 0);
    rxq.delete(); m_ovr = 0; m_ferr = 0; m_perr = 0;
    repeat (2) tick();
    rst = 0; tick();
    rd(1, d); check("post_rst_status", d, exp_status());
    rd(2, d); check("post_rst_ctrl", d, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_controller_v2.md
# uart_controller_v2

Parametrised, register-mapped UART controller: the next-generation serial port on the d16 peripheral bus. It adds:
- configurable FIFO depth;
- a runtime-programmable baud divisor;
- optional parity;
- sticky error flags, an interrupt output and internal loopback.

It contains its own TX serialiser and RX deserialiser (8 data bits, 1 stop bit), so no fixed-divide UART core is instantiated.

## Interface
- FIFO_DEPTH, 16: entries per FIFO; power of two, 2..128.
- CLOCK_FREQUENCY, 50_000_000: clk frequency in Hz.
- BAUD_RATE, 19200: reset baud rate; DEFAULT_DIVISOR = CLOCK_FREQUENCY/BAUD_RATE - 1.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIVISOR.
- wr_en  in  1  write strobe; one write per cycle it is high.
- rd_en  in  1  read strobe; one read per cycle it is high.
- data  in  16  write data.
- data_out  out  16  registered read data.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output; idles high.
- irq  out  1  registered level interrupt.

## Operation
- **DATA write:**
  - pushes data[7:0] into the TX FIFO;
  - if the TX FIFO is full, the byte is dropped and tx_overflow is set.
- **DATA read:** data_out <= {8'h0, RX head}, and the RX FIFO is popped. Reading while empty returns 16'h0000 and does not pop.
- **STATUS read bits:**
  - [0] TX FIFO not full
  - [1] TX FIFO empty and shifter idle
  - [2] RX FIFO not empty
  - [3] rx_overrun
  - [4] frame_error
  - [5] parity_error
  - [6] tx_overflow
  - [7] 0
  - [15:8] RX FIFO count, zero-extended
- **STATUS write:** write-1-to-clear for bits [6:3]; all other bits are ignored.
- **CTRL (read/write):**
  - [0] parity_en
  - [1] parity_odd
  - [2] irq_rx_en
  - [3] irq_tx_done_en
  - [4] irq_err_en
  - [5] loopback
  - [15:6] read 0
- **DIVISOR (read/write):**
  - bit period = DIVISOR+1 clocks;
  - written values below 3 are stored as 3;
  - the value is latched at each frame start, so a write never disturbs a frame in progress.
- **TX FSM, IDLE -> START -> DATA(8, LSB first) -> [PARITY] -> STOP -> IDLE:**
  - in IDLE with the FIFO non-empty, the head is popped and START is entered on the same edge;
  - parity bit = XOR of the data bits, inverted when parity_odd is set.
- **RX path:**
  - rx passes through a 2-flop synchroniser;
  - in loopback the RX engine takes the internal TX serial stream, and the tx pin is held at 1.
- **RX FSM, IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:**
  - a high-to-low transition in IDLE enters START;
  - START samples at (DIVISOR+1)/2 clocks, integer division; a high sample is a false start and returns to IDLE with no flags;
  - DATA, PARITY and STOP are each sampled DIVISOR+1 clocks after the previous sample.
- **RX stop bit:**
  - stop sample = 1: the byte is pushed. If the RX FIFO is full, the byte is dropped and rx_overrun is set. A parity mismatch sets parity_error, but the byte is still pushed.
  - stop sample = 0: frame_error is set, the byte is discarded, and the FSM waits for rx high before IDLE.
- **irq:** registered OR of the following, updating one cycle after its inputs:
  - irq_rx_en & RX not empty;
  - irq_tx_done_en & STATUS[1];
  - irq_err_en & any of STATUS[6:3].

## Timing
- **Reset values:**
  - tx=1, data_out=0, irq=0;
  - CTRL=0, DIVISOR=DEFAULT_DIVISOR;
  - both FIFOs empty, all sticky flags 0, both FSMs in IDLE.
- Reset asserted mid-frame forces tx high immediately and aborts both frames.
- **Register access:**
  - writes take effect on the edge where wr_en=1;
  - reads: data_out is valid the cycle after rd_en=1 and holds until the next read;
  - wr_en and rd_en in the same cycle are both performed.
- **TX latency:** a DATA write at edge N puts the start bit on tx from edge N+1 when TX is idle. Back-to-back frames have zero idle clocks: the next start follows the stop bit directly when the FIFO is non-empty.
- **Frame length:** (10 + parity_en) × (DIVISOR+1) clocks.
- **RX push:** occurs on the edge of the stop-bit sample. STATUS[2] reads 1 on a STATUS read issued the following cycle.
- **Simultaneous push and pop:**
  - when the FIFO is not full, both succeed and the count is unchanged;
  - when the FIFO is full, fullness is judged before the pop, so the push is dropped.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.
- Error flags are set on the sample edge. A W1C and a set in the same cycle leave the flag set.

## Test plan
- Reset, then read all four registers -> DATA 0x0000, STATUS 0x0003, CTRL 0x0000, DIVISOR = DEFAULT_DIVISOR.
- DIVISOR=9, write 0xA5 -> tx falls the next cycle. Expect 10-clock bits, sequence 0,1,0,1,0,0,1,0,1,1; STATUS[1] returns to 1 after 100 clocks.
- DIVISOR=9, CTRL=0x21 (loopback, even parity), write 0x3C -> after 110 clocks STATUS[2]=1 and STATUS[15:8]=1; DATA read returns 0x003C; parity_error=0.
- FIFO_DEPTH=4, loopback, 5 frames sent with no reads -> 4 bytes stored, rx_overrun=1, STATUS[15:8]=4. STATUS write 0x0008 -> bit3=0.
- Drive rx with a 0 stop bit -> frame_error=1, count unchanged. A 3-clock low glitch (DIVISOR=9) -> no flags, no push.
- CTRL=0x04; deliver one byte -> irq rises the cycle after the push and falls the cycle after the DATA read empties the FIFO. Assert rst mid-frame -> tx=1 and irq=0 immediately.
